// File: rtl/point_dispatcher.sv
// Streams every point of the dataset into the kd-tree root once per k-means iteration,
// pulses centroid updates, and repeats until all PEs report stable or the iteration cap is reached.
module point_dispatcher #(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255,
  parameter int NUM_POINTS = 64,
  parameter int MAX_ITERS  = 32,
  localparam int DIM_SIZE  = $clog2(DATA_RANGE),
  localparam int ADDR_W    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1,
  localparam int ITER_W    = $clog2(MAX_ITERS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    pt_rd,
  output logic [ADDR_W-1:0]       pt_addr,
  input  logic [DIM*DIM_SIZE-1:0] pt_data,
  output logic [DIM*DIM_SIZE-1:0] point_out,
  output logic                    receive_point,
  input  logic                    tree_ready,
  input  logic                    assign_done,
  output logic                    start_iter,
  output logic                    update,
  input  logic                    update_done,
  input  logic                    all_stable,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [ITER_W-1:0]       iter_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_ITER_START, S_FETCH, S_WAIT_DATA, S_SEND,
    S_WAIT_ASSIGN, S_ITER_END, S_WAIT_UPDATE, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_POINTS - 1);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITERS);

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_idx;
  logic [ADDR_W-1:0]         r_pt_addr;
  logic [DIM*DIM_SIZE-1:0]   r_point;
  logic [ITER_W-1:0]         r_iter;
  logic                      r_pt_rd, r_recv, r_start_iter, r_update, r_busy, r_done, r_conv;

  logic [ADDR_W-1:0]         w_idx_nxt;
  logic [ITER_W-1:0]         w_iter_nxt;

  assign w_idx_nxt  = r_idx + 1'b1;
  assign w_iter_nxt = r_iter + 1'b1;

  // Outputs are registered alongside the state transition so each one is a clean Moore output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pt_addr    <= '0;
      r_point      <= '0;
      r_iter       <= '0;
      r_pt_rd      <= 1'b0;
      r_recv       <= 1'b0;
      r_start_iter <= 1'b0;
      r_update     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_conv       <= 1'b0;
    end else begin
      r_start_iter <= 1'b0;
      r_pt_rd      <= 1'b0;
      r_update     <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_ITER_START;
            r_start_iter <= 1'b1;
            r_busy       <= 1'b1;
            r_iter       <= '0;
            r_conv       <= 1'b0;
            r_idx        <= '0;
          end
        end
        S_ITER_START: begin
          r_idx     <= '0;
          r_pt_addr <= '0;
          r_pt_rd   <= 1'b1;
          r_state   <= S_FETCH;
        end
        S_FETCH: r_state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          r_point <= pt_data;
          r_recv  <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (tree_ready) begin
            r_recv  <= 1'b0;
            r_state <= S_WAIT_ASSIGN;
          end
        end
        S_WAIT_ASSIGN: begin
          if (assign_done) begin
            if (r_idx == LAST_IDX) begin
              r_update <= 1'b1;
              r_state  <= S_ITER_END;
            end else begin
              r_idx     <= w_idx_nxt;
              r_pt_addr <= w_idx_nxt;
              r_pt_rd   <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        S_ITER_END: r_state <= S_WAIT_UPDATE;
        S_WAIT_UPDATE: begin
          if (update_done) begin
            r_iter <= w_iter_nxt;
            if (all_stable || (w_iter_nxt == ITER_CAP)) begin
              r_conv  <= all_stable;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_start_iter <= 1'b1;
              r_state      <= S_ITER_START;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_recv  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pt_rd         = r_pt_rd;
  assign pt_addr       = r_pt_addr;
  assign point_out     = r_point;
  assign receive_point = r_recv;
  assign start_iter    = r_start_iter;
  assign update        = r_update;
  assign busy          = r_busy;
  assign done          = r_done;
  assign converged     = r_conv;
  assign iter_count    = r_iter;

endmodule

// File: tb/tb_point_dispatcher.sv
// Scoreboard bench for point_dispatcher: a responder models point memory and the PE tree,
// a monitor pops expected addresses, points and run results as the DUT presents them.
module tb_point_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pt_rd;
  logic [1:0]  pt_addr;
  logic [23:0] pt_data = '0;
  logic [23:0] point_out;
  logic        receive_point;
  logic        tree_ready = 1'b1;
  logic        assign_done = 1'b0;
  logic        start_iter;
  logic        update;
  logic        update_done = 1'b0;
  logic        all_stable = 1'b0;
  logic        busy;
  logic        done;
  logic        converged;
  logic [1:0]  iter_count;

  point_dispatcher #(.DIM(3), .DATA_RANGE(255), .NUM_POINTS(4), .MAX_ITERS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_data(pt_data),
    .point_out(point_out), .receive_point(receive_point), .tree_ready(tree_ready),
    .assign_done(assign_done), .start_iter(start_iter), .update(update),
    .update_done(update_done), .all_stable(all_stable), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] v; int hold; } pt_t;
  typedef struct { int iters; int conv; } res_t;

  int    aq[$];
  pt_t   pq[$];
  res_t  rq[$];
  logic [23:0] mem [4];

  int total = 0;
  int bad   = 0;

  // stimulus-owned knobs read by the responder
  logic [23:0] stall_pt = '0;
  int          stall_n = 0;
  int          conv_iter = 0;
  bit          spurious = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got output with empty expectation queue, want none", nm);
  endtask

  // Responder: point memory with one-cycle read latency, tree handshake and PE pulses.
  int r_cnt, r_ucnt, r_st, r_it;
  logic r_rdq;
  logic [1:0] r_addrq;
  logic r_ad, r_ud, r_stab;
  initial begin
    r_cnt = 0; r_ucnt = 0; r_st = 0; r_it = 0; r_rdq = 1'b0; r_addrq = '0;
    forever begin
      @(posedge clk); #1;
      r_ad = 1'b0; r_ud = 1'b0; r_stab = 1'b1;
      pt_data = r_rdq ? mem[r_addrq] : 24'h5A5A5A;
      r_rdq = pt_rd; r_addrq = pt_addr;
      if (rst) begin
        r_cnt = 0; r_ucnt = 0; r_st = 0; r_it = 0; tree_ready = 1'b1;
      end else begin
        if (done) r_it = 0;
        if (start_iter) r_it++;
        if (receive_point && r_st < stall_n && point_out == stall_pt) begin
          tree_ready = 1'b0; r_st++;
        end else tree_ready = 1'b1;
        if (!receive_point) r_st = 0;
        if (r_cnt != 0) begin r_cnt--; if (r_cnt == 0) r_ad = 1'b1; end
        if (receive_point && tree_ready) r_cnt = 2;
        if (r_ucnt != 0) begin
          r_ucnt--;
          if (r_ucnt == 0) begin
            r_ud = 1'b1;
            r_stab = (conv_iter != 0) && (r_it >= conv_iter);
          end
        end
        if (update) r_ucnt = 2;
        if (spurious && pt_rd) begin r_ad = 1'b1; r_ud = 1'b1; end
      end
      assign_done = r_ad; update_done = r_ud; all_stable = r_stab;
    end
  end

  // Monitor: compares every DUT output event against the expectation queues.
  int m_len, m_nsi, m_nup, m_a;
  logic [23:0] m_first;
  pt_t  m_p;
  res_t m_r;
  initial begin
    m_len = 0; m_nsi = 0; m_nup = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_len = 0; m_nsi = 0; m_nup = 0;
      end else begin
        if (start_iter) m_nsi++;
        if (update) m_nup++;
        if (pt_rd) begin
          if (aq.size() == 0) miss("pt_rd_extra");
          else begin m_a = aq.pop_front(); chk("pt_addr", 32'(pt_addr), 32'(m_a)); end
        end
        if (receive_point) begin
          if (m_len == 0) m_first = point_out;
          else chk("point_hold", 32'(point_out), 32'(m_first));
          m_len++;
          if (tree_ready) begin
            if (pq.size() == 0) miss("point_extra");
            else begin
              m_p = pq.pop_front();
              chk("point_val", 32'(point_out), 32'(m_p.v));
              chk("point_len", 32'(m_len), 32'(m_p.hold));
            end
            m_len = 0;
          end
        end
        if (done) begin
          if (rq.size() == 0) miss("done_extra");
          else begin
            m_r = rq.pop_front();
            chk("iter_count", 32'(iter_count), 32'(m_r.iters));
            chk("converged", 32'(converged), 32'(m_r.conv));
            chk("start_iter_n", 32'(m_nsi), 32'(m_r.iters));
            chk("update_n", 32'(m_nup), 32'(m_r.iters));
            chk("done_busy", 32'(busy), 32'd1);
          end
          m_nsi = 0; m_nup = 0;
        end
      end
    end
  end

  task automatic wait_done();
    int c = 0;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input int conv_it, input int iters, input int conv, input bit poke,
                     input bit chk_clear);
    pt_t  p;
    res_t r;
    int   c;
    conv_iter = conv_it;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 4; i++) begin
        aq.push_back(i);
        p.v = mem[i];
        p.hold = (stall_n != 0 && mem[i] == stall_pt) ? stall_n + 1 : 1;
        pq.push_back(p);
      end
    end
    r.iters = iters; r.conv = conv;
    rq.push_back(r);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("lat_start_iter", 32'(start_iter), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    if (chk_clear) begin
      chk("clr_iter_count", 32'(iter_count), 32'd0);
      chk("clr_converged", 32'(converged), 32'd0);
    end
    @(negedge clk);
    chk("lat_pt_rd", 32'(pt_rd), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("lat_receive", 32'(receive_point), 32'd1);
    if (poke) begin
      c = 0;
      while (!(receive_point && tree_ready) && c < 50) begin @(negedge clk); c++; end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_done();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_iter_hold", 32'(iter_count), 32'(iters));
    chk("idle_conv_hold", 32'(converged), 32'(conv));
    repeat (3) @(negedge clk);
    chk("addr_q_left", 32'(aq.size()), 32'd0);
    chk("pt_q_left", 32'(pq.size()), 32'd0);
    chk("res_q_left", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    int c;
    mem[0] = 24'd101; mem[1] = 24'd16777215; mem[2] = 24'd8388608; mem[3] = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_point_out", 32'(point_out), 32'd0);
    chk("rst_pt_addr", 32'(pt_addr), 32'd0);
    rst = 1'b0;

    // reset while the root stalls the first point
    stall_pt = 24'd101; stall_n = 100;
    aq.push_back(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (!receive_point && c < 50) begin @(negedge clk); c++; end
    chk("pre_rst_receive", 32'(receive_point), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_receive", 32'(receive_point), 32'd0);
    chk("mid_rst_point_out", 32'(point_out), 32'd0);
    chk("mid_rst_iter", 32'(iter_count), 32'd0);
    chk("mid_rst_conv", 32'(converged), 32'd0);
    rst = 1'b0;
    aq.delete(); pq.delete(); rq.delete();
    stall_n = 0;

    // single iteration, all stable
    run(1, 1, 1, 1'b0, 1'b0);

    // root stalls 3 cycles on one point
    mem[0] = 24'd4194304; mem[1] = 24'd7; mem[2] = 24'h123456; mem[3] = 24'hABCDEF;
    stall_pt = 24'd4194304; stall_n = 3;
    run(1, 1, 1, 1'b0, 1'b0);
    stall_n = 0;

    // start during WAIT_ASSIGN and stray pulses during FETCH are ignored
    mem[0] = 24'd101; mem[1] = 24'd16777215; mem[2] = 24'd8388608; mem[3] = 24'd0;
    spurious = 1'b1;
    run(1, 1, 1, 1'b1, 1'b0);
    spurious = 1'b0;

    // converge on iteration 2, then a never-stable run hitting the cap
    run(2, 2, 1, 1'b0, 1'b0);
    run(0, 3, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/point_dispatcher.md
Name: point_dispatcher

Overview:
- Sequencer directly upstream of the kd-tree root cluster PE.
- Each k-means iteration: pulses the tree's start-iteration, streams every point from point memory into the root one at a time, waits for leaf assignment per point, pulses a centroid update, then checks global stability.
- Runs iterations until every PE reports stable or the iteration cap is hit; reports iteration count and convergence to the host.

Parameters:
DIM, 3, coordinates per point
DATA_RANGE, 255, max coordinate value; DIM_SIZE = $clog2(DATA_RANGE) = 8
NUM_POINTS, 64, points per dataset (>=1); ADDR_W = max(1,$clog2(NUM_POINTS))
MAX_ITERS, 32, iteration cap (>=1); ITER_W = $clog2(MAX_ITERS+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin clustering run; sampled only in IDLE
pt_rd  out  1  point memory read strobe
pt_addr  out  ADDR_W  point memory address
pt_data  in  DIM*DIM_SIZE  read data, valid the cycle after pt_rd
point_out  out  DIM*DIM_SIZE  point to root PE point_in
receive_point  out  1  point valid to root PE
tree_ready  in  1  root accepts point this cycle
assign_done  in  1  one-cycle pulse: current point reached its leaf
start_iter  out  1  one-cycle pulse to all PEs
update  out  1  one-cycle pulse: recompute centers
update_done  in  1  pulse: centers recomputed, stable flags valid
all_stable  in  1  AND of every PE stable output
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at run end
converged  out  1  run ended because all_stable
iter_count  out  ITER_W  iterations completed in current/last run

Behaviour:
- Reset (any state, mid-operation included): state IDLE next cycle; all outputs 0, including point_out, pt_addr, iter_count, converged; point index and latch cleared. In-flight assign_done/update_done pulses discarded.
- FSM, Moore outputs from registered state:
  IDLE: start=1 -> ITER_START; clear iter_count, converged, idx.
  ITER_START: start_iter=1 one cycle; idx=0 -> FETCH.
  FETCH: pt_rd=1, pt_addr=idx -> WAIT_DATA.
  WAIT_DATA: latch pt_data into point register -> SEND.
  SEND: receive_point=1, point_out=latched point, held stable while tree_ready=0; on edge with tree_ready=1 -> WAIT_ASSIGN.
  WAIT_ASSIGN: receive_point=0; on assign_done=1: if idx==NUM_POINTS-1 -> ITER_END else idx+1 -> FETCH.
  ITER_END: update=1 one cycle -> WAIT_UPDATE.
  WAIT_UPDATE: on update_done=1, iter_count+1; all_stable=1 -> converged=1, DONE; else iter_count+1==MAX_ITERS -> converged=0, DONE; else ITER_START.
  DONE: done=1 one cycle -> IDLE.
- Latency: start sampled at edge N -> start_iter high in cycle N+1, pt_rd in N+2, receive_point in N+4. Best case per point 4 cycles (tree_ready and assign_done already high on entry).
- point_out keeps last value outside SEND (root ignores it without receive_point); zero only after reset.
- busy=1 in every state except IDLE; done and busy both 1 in DONE.
- start while busy ignored; start held high through DONE restarts the next cycle after IDLE.
- assign_done outside WAIT_ASSIGN, update_done outside WAIT_UPDATE, tree_ready outside SEND: ignored.
- all_stable sampled only on the update_done edge.
- NUM_POINTS=1: ITER_END after first assign_done. iter_count never exceeds MAX_ITERS. converged holds until next start accepted or reset.

Test Plan:
1. rst=1 two cycles mid-SEND with tree_ready=0 -> next cycle IDLE, busy=0, receive_point=0, point_out=0, iter_count=0.
2. NUM_POINTS=4, memory {24'd101,24'd16777215,24'd8388608,24'd0}, tree_ready=1, assign_done two cycles after each receive_point, update_done with all_stable=1 -> four receive_points carrying those values in order, one update pulse, iter_count=1, converged=1, done pulse.
3. tree_ready low 3 cycles during SEND of 24'd4194304 -> receive_point and point_out stable 4 cycles, WAIT_ASSIGN entered only after tree_ready edge.
4. MAX_ITERS=3, all_stable=0 always -> exactly 3 start_iter and 3 update pulses, iter_count=3, converged=0, done.
5. start pulsed during WAIT_ASSIGN and spurious assign_done during FETCH -> no restart, idx unchanged, point sequence unaffected.
6. Convergence on iteration 2 of MAX_ITERS=5 -> iter_count=2, converged=1; new start clears converged and iter_count to 0 next cycle.
